// File: rtl/sr_pulse_gen.sv
// Synchronizes and debounces raw set/reset buttons, then emits one-cycle
// arbitrated set/reset pulses for the downstream SR flip-flop.
module sr_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic set_raw,
    input  logic reset_raw,
    output logic st_pulse,
    output logic rs_pulse,
    output logic set_level,
    output logic reset_level,
    output logic conflict
);

    localparam int unsigned     NCH     = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel 0 carries set, channel 1 carries reset.
    logic [NCH-1:0]            s1_q, s2_q;
    logic [NCH-1:0]            stable_q, stable_d;
    logic [NCH-1:0]            stable_dly_q;
    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]            req_c;
    logic                      st_q, st_d;
    logic                      rs_q, rs_d;
    logic                      cf_q, cf_d;

    // Debounce, rising-edge detect and arbitration.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < int'(NCH); i++) begin
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        req_c = stable_q & ~stable_dly_q;
        // Reset wins a tie so the flip-flop never sees both inputs high.
        st_d  = req_c[0] & ~req_c[1];
        rs_d  = req_c[1];
        cf_d  = req_c[0] & req_c[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= '0;
            s2_q         <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            cnt_q        <= '0;
            st_q         <= 1'b0;
            rs_q         <= 1'b0;
            cf_q         <= 1'b0;
        end else begin
            s1_q         <= {reset_raw, set_raw};
            s2_q         <= s1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            st_q         <= st_d;
            rs_q         <= rs_d;
            cf_q         <= cf_d;
        end
    end

    assign st_pulse    = st_q;
    assign rs_pulse    = rs_q;
    assign conflict    = cf_q;
    assign set_level   = stable_q[0];
    assign reset_level = stable_q[1];

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Scoreboard bench for sr_pulse_gen: a per-edge reference model queues the
// expected outputs and an independent negedge monitor pops and compares.
module tb_sr_pulse_gen;

    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic rst;
    logic set_raw;
    logic reset_raw;
    logic st_pulse, rs_pulse, set_level, reset_level, conflict;

    sr_pulse_gen #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .set_raw    (set_raw),
        .reset_raw  (reset_raw),
        .st_pulse   (st_pulse),
        .rs_pulse   (rs_pulse),
        .set_level  (set_level),
        .reset_level(reset_level),
        .conflict   (conflict)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic st;
        logic rs;
        logic cf;
        logic sl;
        logic rl;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   st_seen = 0;

    // Reference model: raw captures since reset, per-channel run of samples
    // disagreeing with the accepted level, accepted levels, last-edge rises.
    logic       cap_s[$];
    logic       cap_r[$];
    logic       run_s[$];
    logic       run_r[$];
    logic [1:0] m_level;
    logic [1:0] rise_prev;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    // A level is accepted once D consecutive synchronized samples differ from it.
    function automatic logic accept(inout logic run[$], input logic sample,
                                    input logic level);
        if (sample == level) begin
            run.delete();
            return 1'b0;
        end
        run.push_back(sample);
        if (run.size() == D) begin
            run.delete();
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_edge(input logic s, input logic r, input logic rs);
        exp_t       e;
        logic [1:0] rise;
        logic [1:0] sync;
        if (rs) begin
            cap_s.delete(); cap_r.delete();
            run_s.delete(); run_r.delete();
            m_level   = 2'b00;
            rise_prev = 2'b00;
            e         = '0;
        end else begin
            // The debouncer sees the raw value captured two edges earlier.
            sync[0] = (cap_s.size() >= 2) ? cap_s[cap_s.size()-2] : 1'b0;
            sync[1] = (cap_r.size() >= 2) ? cap_r[cap_r.size()-2] : 1'b0;
            e.st = rise_prev[0] & ~rise_prev[1];
            e.rs = rise_prev[1];
            e.cf = rise_prev[0] & rise_prev[1];
            rise = 2'b00;
            if (accept(run_s, sync[0], m_level[0])) begin
                m_level[0] = sync[0];
                rise[0]    = sync[0];
            end
            if (accept(run_r, sync[1], m_level[1])) begin
                m_level[1] = sync[1];
                rise[1]    = sync[1];
            end
            e.sl      = m_level[0];
            e.rl      = m_level[1];
            rise_prev = rise;
            cap_s.push_back(s);
            cap_r.push_back(r);
            if (cap_s.size() > 2) void'(cap_s.pop_front());
            if (cap_r.size() > 2) void'(cap_r.pop_front());
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic s, input logic r, input logic rs);
        set_raw   = s;
        reset_raw = r;
        rst       = rs;
        @(posedge clk);
        cyc++;
        model_edge(s, r, rs);
        @(negedge clk);
    endtask

    // Monitor: compares every cycle's outputs against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("st_pulse",    int'(st_pulse),    int'(e.st));
            chk("rs_pulse",    int'(rs_pulse),    int'(e.rs));
            chk("conflict",    int'(conflict),    int'(e.cf));
            chk("set_level",   int'(set_level),   int'(e.sl));
            chk("reset_level", int'(reset_level), int'(e.rl));
            chk("no_overlap",  int'(st_pulse & rs_pulse), 0);
            if (st_pulse === 1'b1) st_seen++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int hs, hr, n0;
        logic vs, vr;
        m_level   = 2'b00;
        rise_prev = 2'b00;

        // Reset then idle
        repeat (3) step(1'b0, 1'b0, 1'b1);
        chk("reset_st", int'(st_pulse), 0);
        chk("reset_rs", int'(rs_pulse), 0);
        repeat (20) step(1'b0, 1'b0, 1'b0);

        // Clean press, held 30 cycles; edge k is the k-th step from 0
        for (int k = 0; k < 30; k++) begin
            step(1'b1, 1'b0, 1'b0);
            if (k == 4) chk("press_level_e4", int'(set_level), 0);
            if (k == 5) chk("press_level_e5", int'(set_level), 1);
            if (k == 5) chk("press_pulse_e5", int'(st_pulse), 0);
            if (k == 6) chk("press_pulse_e6", int'(st_pulse), 1);
            if (k == 7) chk("press_pulse_e7", int'(st_pulse), 0);
        end
        repeat (2) step(1'b0, 1'b0, 1'b1);

        // Bounce rejection then steady press on reset channel
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        chk("bounce_level", int'(reset_level), 0);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, 1'b0);
            if (k == 6) chk("bounce_press_e6", int'(rs_pulse), 1);
        end
        repeat (2) step(1'b0, 1'b0, 1'b1);

        // Simultaneous rise
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b1, 1'b0);
            if (k == 6) begin
                chk("simul_rs", int'(rs_pulse), 1);
                chk("simul_cf", int'(conflict), 1);
                chk("simul_st", int'(st_pulse), 0);
            end
        end
        repeat (2) step(1'b0, 1'b0, 1'b1);

        // Release and re-press: two set pulses, level falls 5 edges after release
        n0 = st_seen;
        repeat (10) step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b0);
            if (k == 4) chk("release_level_e4", int'(set_level), 1);
            if (k == 5) chk("release_level_e5", int'(set_level), 0);
        end
        repeat (10) step(1'b1, 1'b0, 1'b0);
        chk("repress_count", st_seen - n0, 2);
        repeat (2) step(1'b0, 1'b0, 1'b1);

        // Reset mid-debounce at edge 4: first capture edge 5, pulse edge 11
        for (int k = 0; k < 15; k++) begin
            step(1'b1, 1'b0, (k == 4) ? 1'b1 : 1'b0);
            if (k == 6)  chk("midrst_e6",  int'(st_pulse), 0);
            if (k == 11) chk("midrst_e11", int'(st_pulse), 1);
        end
        repeat (2) step(1'b0, 1'b0, 1'b1);

        // Randomized bouncy levels on both channels with occasional resets
        hs = 0; hr = 0; vs = 1'b0; vr = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (hs == 0) begin
                vs = 1'($urandom_range(0, 1));
                hs = int'($urandom_range(1, 9));
            end
            if (hr == 0) begin
                vr = 1'($urandom_range(0, 1));
                hr = int'($urandom_range(1, 9));
            end
            step(vs, vr, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
            hs--; hr--;
        end

        repeat (8) step(1'b0, 1'b0, 1'b0);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
